// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared definitions for the register-file write-back arbiter slice:
//   register file geometry, the write-request record and the round-robin
//   pointer advance helper.
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

  // Register file geometry
  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = $clog2(REG_COUNT);
  localparam int DATA_W    = 64;

  // One write-back request at the default register file geometry
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Next round-robin pointer: the requester after the one just served
  function automatic int unsigned rr_next(input int unsigned idx,
                                          input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Bundle of the write-back requester handshakes, the register file write
//   port and the RAW hazard lookup.
//     req_valid/req_ready  per-requester handshake (N_REQ bits each)
//     req_addr/req_data    packed per-requester address / data
//     rf_wr_en/addr/data   register file write port
//     grant_idx            requester currently driving the write port
//     chk_addr0/1          hazard lookup addresses (rs1/rs2)
//     chk_busy0/1          held, uncommitted write targets chk_addrK
//   master: requesters + issue logic; slave: the arbiter.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;

  logic                    rf_wr_en;
  logic [ADDR_W-1:0]       rf_wr_addr;
  logic [DATA_W-1:0]       rf_wr_data;
  logic [IDX_W-1:0]        grant_idx;

  logic [ADDR_W-1:0]       chk_addr0;
  logic [ADDR_W-1:0]       chk_addr1;
  logic                    chk_busy0;
  logic                    chk_busy1;

  modport master (
    output req_valid, req_addr, req_data, chk_addr0, chk_addr1,
    input  req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, grant_idx,
           chk_busy0, chk_busy1
  );

  modport slave (
    input  req_valid, req_addr, req_data, chk_addr0, chk_addr1,
    output req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, grant_idx,
           chk_busy0, chk_busy1
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   N-way round-robin priority picker. Purely combinational.
//     req        request vector
//     ptr        index of the highest-priority requester
//     grant      one-hot grant (all zero when nothing requests)
//     grant_idx  encoded grant index (0 when nothing requests)
//   The search starts at ptr and walks upward with wrap-around.
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    // NOTE: every variable assigned here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the register file's single write port between N_REQ write-back
//   requesters. Each requester owns a one-entry holding register; a
//   round-robin arbiter drains one held write per cycle straight onto the
//   write port, and busy flags expose held writes to the issue logic.
//     clk, reset  clock, asynchronous active-high reset
//     bus         regfile_wb_arbiter_if.slave (handshakes, write port,
//                 hazard lookup)
//   Parameters: N_REQ (2..4), DATA_W, ADDR_W, ZERO_DISCARD (drop writes to
//   register 0 at the handshake).
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int N_REQ        = 2,
  parameter int DATA_W       = regfile_wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W       = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int ZERO_DISCARD = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_wb_arbiter_if.slave     bus
);
  import regfile_wb_arbiter_pkg::*;

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } hold_t;

  logic [N_REQ-1:0] hold_valid_q;
  hold_t            hold_q [N_REQ];
  logic [IDX_W-1:0] rr_ptr_q;

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] keep;
  logic             rf_wr_en;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .req       (hold_valid_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A slot draining this cycle can take a new write at the same edge.
  assign bus.req_ready = ~hold_valid_q | grant;

  // keep=0 marks a handshaken write to register 0 that is silently dropped.
  always_comb begin
    accept = '0;
    keep   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      accept[i] = bus.req_valid[i] && bus.req_ready[i];
      keep[i]   = !((ZERO_DISCARD != 0) &&
                    (bus.req_addr[i*ADDR_W +: ADDR_W] == '0));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          hold_valid_q[i] <= keep[i];
        end else if (grant[i]) begin
          hold_valid_q[i] <= 1'b0;
        end
      end
      if (|hold_valid_q) begin
        rr_ptr_q <= IDX_W'(rr_next(32'(grant_idx), N_REQ));
      end
    end
  end

  // NOTE: the hold payload has no reset; it is only ever observed through
  // hold_valid_q, which is reset, so resetting it would only cost wiring.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        hold_q[i] <= '{addr: bus.req_addr[i*ADDR_W +: ADDR_W],
                       data: bus.req_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  // Write port is driven straight from the granted hold; the register file
  // commits at the same edge that clears the grant.
  assign rf_wr_en       = |hold_valid_q;
  assign bus.rf_wr_en   = rf_wr_en;
  assign bus.rf_wr_addr = rf_wr_en ? hold_q[grant_idx].addr : '0;
  assign bus.rf_wr_data = rf_wr_en ? hold_q[grant_idx].data : '0;
  assign bus.grant_idx  = grant_idx;

  // The entry draining this cycle still counts: the register file only
  // holds the new value after the edge. Register 0 never reaches a hold
  // when discarding, so it can never read busy.
  always_comb begin
    bus.chk_busy0 = 1'b0;
    bus.chk_busy1 = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (hold_valid_q[i] && (hold_q[i].addr == bus.chk_addr0)) bus.chk_busy0 = 1'b1;
      if (hold_valid_q[i] && (hold_q[i].addr == bus.chk_addr1)) bus.chk_busy1 = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter (N_REQ=2, ZERO_DISCARD=1).
//   Inputs are driven 1 time unit after posedge; outputs sampled at negedge.
//   A register file model records every write seen on the write port.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int N_REQ = 2;

  logic clk = 1'b0;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] rf_mem [REG_COUNT] = '{default: '0};
  int                wr_count = 0;

  regfile_wb_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wb_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_DISCARD(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file model: commits whatever the write port shows at the edge.
  always @(posedge clk) begin
    if (!reset && bus.rf_wr_en) begin
      rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input wr_req_t r);
    bus.req_valid[i]                = v;
    bus.req_addr[i*ADDR_W +: ADDR_W] = r.addr;
    bus.req_data[i*DATA_W +: DATA_W] = r.data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.chk_addr0 = '0;
    bus.chk_addr1 = '0;
    #1;
    vectors++;
    if ({bus.rf_wr_en, bus.req_ready, bus.chk_busy0, bus.chk_busy1} !== 5'b0_11_0_0) begin
      miscompares++;
      $display("FAIL reset_flags: got en/ready/busy0/busy1=%b want 0_11_0_0",
               {bus.rf_wr_en, bus.req_ready, bus.chk_busy0, bus.chk_busy1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.rf_wr_addr, bus.rf_wr_data, bus.grant_idx} !== '0) begin
      miscompares++;
      $display("FAIL reset_port: got addr=%0d data=%h grant=%0d want 0/0/0",
               bus.rf_wr_addr, bus.rf_wr_data, bus.grant_idx);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_contention();
    logic [0:0] exp_g;
    drive(0, 1'b1, '{addr: 5'd5, data: 64'hA5});
    drive(1, 1'b1, '{addr: 5'd6, data: 64'hB6});
    @(negedge clk);
    vectors++;
    if ({bus.rf_wr_en, bus.req_ready} !== 3'b0_11) begin
      miscompares++;
      $display("FAIL cont_start: got en/ready=%b want 0_11", {bus.rf_wr_en, bus.req_ready});
    end
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      exp_g = 1'(k % 2);
      vectors++;
      if ({bus.rf_wr_en, bus.grant_idx, bus.req_ready} !==
          {1'b1, exp_g, (exp_g == 1'b0) ? 2'b01 : 2'b10}) begin
        miscompares++;
        $display("FAIL cont_grant[%0d]: got en/grant/ready=%b want en=1 grant=%0d",
                 k, {bus.rf_wr_en, bus.grant_idx, bus.req_ready}, exp_g);
      end
      vectors++;
      if (bus.rf_wr_addr !== ((exp_g == 1'b0) ? 5'd5 : 5'd6)) begin
        miscompares++;
        $display("FAIL cont_addr[%0d]: got %0d want %0d", k, bus.rf_wr_addr,
                 (exp_g == 1'b0) ? 5 : 6);
      end
    end
    step();
    drive(0, 1'b0, '{addr: 5'd0, data: 64'h0});
    drive(1, 1'b0, '{addr: 5'd0, data: 64'h0});
    @(negedge clk);
    vectors++;
    if ({bus.rf_wr_en, bus.grant_idx, bus.req_ready} !== 4'b1_0_01) begin
      miscompares++;
      $display("FAIL cont_drain0: got en/grant/ready=%b want 1_0_01",
               {bus.rf_wr_en, bus.grant_idx, bus.req_ready});
    end
    step();
    @(negedge clk);
    vectors++;
    if ({bus.rf_wr_en, bus.grant_idx, bus.req_ready} !== 4'b1_1_11) begin
      miscompares++;
      $display("FAIL cont_drain1: got en/grant/ready=%b want 1_1_11",
               {bus.rf_wr_en, bus.grant_idx, bus.req_ready});
    end
    step();
    @(negedge clk);
    vectors++;
    if ({bus.rf_wr_en, rf_mem[5], rf_mem[6]} !== {1'b0, 64'hA5, 64'hB6}) begin
      miscompares++;
      $display("FAIL cont_final: got en=%b r5=%h r6=%h want 0/a5/b6",
               bus.rf_wr_en, rf_mem[5], rf_mem[6]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int wr_snap;
    wr_snap = wr_count;
    for (int k = 1; k <= 8; k++) begin
      drive(1, 1'b1, '{addr: 5'(k), data: 64'(32'h100 + k)});
      @(negedge clk);
      vectors++;
      if (bus.req_ready[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", k, bus.req_ready[1]);
      end
      if (k > 1) begin
        vectors++;
        if ({bus.rf_wr_en, bus.grant_idx, bus.rf_wr_addr, bus.rf_wr_data} !==
            {1'b1, 1'b1, 5'(k - 1), 64'(32'h100 + k - 1)}) begin
          miscompares++;
          $display("FAIL b2b_commit[%0d]: got en=%b g=%0d addr=%0d data=%h want 1/1/%0d/%h",
                   k, bus.rf_wr_en, bus.grant_idx, bus.rf_wr_addr, bus.rf_wr_data,
                   k - 1, 32'h100 + k - 1);
        end
      end
      step();
    end
    drive(1, 1'b0, '{addr: 5'd0, data: 64'h0});
    @(negedge clk);
    vectors++;
    if ({bus.rf_wr_en, bus.rf_wr_addr} !== {1'b1, 5'd8}) begin
      miscompares++;
      $display("FAIL b2b_last: got en=%b addr=%0d want 1/8", bus.rf_wr_en, bus.rf_wr_addr);
    end
    step();
    @(negedge clk);
    vectors++;
    if ((wr_count - wr_snap) !== 8 || bus.rf_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_count: got writes=%0d en=%b want 8/0", wr_count - wr_snap, bus.rf_wr_en);
    end
    step();
  endtask

  task automatic test_busy_collision();
    bus.chk_addr1 = 5'd9;
    drive(0, 1'b1, '{addr: 5'd9, data: 64'hAAAA});
    drive(1, 1'b1, '{addr: 5'd9, data: 64'hBBBB});
    @(negedge clk);
    vectors++;
    if (bus.chk_busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL coll_busy_pre: got %b want 0", bus.chk_busy1);
    end
    step();
    drive(0, 1'b0, '{addr: 5'd0, data: 64'h0});
    drive(1, 1'b0, '{addr: 5'd0, data: 64'h0});
    @(negedge clk);
    vectors++;
    if ({bus.chk_busy1, bus.grant_idx, bus.rf_wr_data} !== {1'b1, 1'b0, 64'hAAAA}) begin
      miscompares++;
      $display("FAIL coll_first: got busy1=%b g=%0d data=%h want 1/0/aaaa",
               bus.chk_busy1, bus.grant_idx, bus.rf_wr_data);
    end
    step();
    @(negedge clk);
    vectors++;
    if ({bus.chk_busy1, bus.grant_idx, bus.rf_wr_data} !== {1'b1, 1'b1, 64'hBBBB}) begin
      miscompares++;
      $display("FAIL coll_second: got busy1=%b g=%0d data=%h want 1/1/bbbb",
               bus.chk_busy1, bus.grant_idx, bus.rf_wr_data);
    end
    step();
    @(negedge clk);
    vectors++;
    if ({bus.chk_busy1, rf_mem[9]} !== {1'b0, 64'hBBBB}) begin
      miscompares++;
      $display("FAIL coll_final: got busy1=%b r9=%h want 0/bbbb", bus.chk_busy1, rf_mem[9]);
    end
    step();
  endtask

  task automatic test_single();
    bus.chk_addr0 = 5'd3;
    drive(0, 1'b1, '{addr: 5'd3, data: 64'hDEAD_BEEF});
    @(negedge clk);
    vectors++;
    if ({bus.req_ready[0], bus.rf_wr_en, bus.chk_busy0} !== 3'b1_0_0) begin
      miscompares++;
      $display("FAIL single_pre: got ready0/en/busy0=%b want 1_0_0",
               {bus.req_ready[0], bus.rf_wr_en, bus.chk_busy0});
    end
    step();
    drive(0, 1'b0, '{addr: 5'd0, data: 64'h0});
    @(negedge clk);
    vectors++;
    if ({bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, bus.grant_idx} !==
        {1'b1, 5'd3, 64'hDEAD_BEEF, 1'b0}) begin
      miscompares++;
      $display("FAIL single_port: got en=%b addr=%0d data=%h g=%0d want 1/3/deadbeef/0",
               bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, bus.grant_idx);
    end
    vectors++;
    if ({bus.chk_busy0, bus.req_ready} !== 3'b1_11) begin
      miscompares++;
      $display("FAIL single_busy: got busy0/ready=%b want 1_11", {bus.chk_busy0, bus.req_ready});
    end
    step();
    @(negedge clk);
    vectors++;
    if ({bus.rf_wr_en, bus.chk_busy0, rf_mem[3]} !== {1'b0, 1'b0, 64'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL single_after: got en=%b busy0=%b r3=%h want 0/0/deadbeef",
               bus.rf_wr_en, bus.chk_busy0, rf_mem[3]);
    end
    step();
  endtask

  task automatic test_zero_addr();
    int wr_snap;
    wr_snap = wr_count;
    bus.chk_addr0 = 5'd0;
    drive(0, 1'b1, '{addr: 5'd0, data: 64'h1234});
    @(negedge clk);
    vectors++;
    if (bus.req_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_ready: got %b want 1", bus.req_ready[0]);
    end
    step();
    drive(0, 1'b0, '{addr: 5'd0, data: 64'h0});
    @(negedge clk);
    vectors++;
    if ({bus.rf_wr_en, bus.chk_busy0, bus.req_ready} !== 4'b0_0_11) begin
      miscompares++;
      $display("FAIL zero_drop: got en/busy0/ready=%b want 0_0_11",
               {bus.rf_wr_en, bus.chk_busy0, bus.req_ready});
    end
    step();
    @(negedge clk);
    vectors++;
    if ((wr_count - wr_snap) !== 0) begin
      miscompares++;
      $display("FAIL zero_writes: got %0d want 0", wr_count - wr_snap);
    end
    step();
  endtask

  task automatic test_reset_midstream();
    int wr_snap;
    wr_snap = wr_count;
    bus.chk_addr0 = 5'd12;
    bus.chk_addr1 = 5'd13;
    drive(0, 1'b1, '{addr: 5'd12, data: 64'hC0});
    drive(1, 1'b1, '{addr: 5'd13, data: 64'hD0});
    step();
    drive(0, 1'b0, '{addr: 5'd0, data: 64'h0});
    drive(1, 1'b0, '{addr: 5'd0, data: 64'h0});
    vectors++;
    if ({bus.rf_wr_en, bus.chk_busy0, bus.chk_busy1} !== 3'b111) begin
      miscompares++;
      $display("FAIL mid_loaded: got en/busy0/busy1=%b want 111",
               {bus.rf_wr_en, bus.chk_busy0, bus.chk_busy1});
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.rf_wr_en, bus.req_ready, bus.chk_busy0, bus.chk_busy1, bus.rf_wr_addr} !==
        {1'b0, 2'b11, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: got en=%b ready=%b busy=%b%b addr=%0d want 0/11/00/0",
               bus.rf_wr_en, bus.req_ready, bus.chk_busy0, bus.chk_busy1, bus.rf_wr_addr);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    @(negedge clk);
    vectors++;
    if ({bus.rf_wr_en, rf_mem[12], rf_mem[13]} !== '0 || (wr_count - wr_snap) !== 0) begin
      miscompares++;
      $display("FAIL mid_discard: got en=%b r12=%h r13=%h writes=%0d want 0/0/0/0",
               bus.rf_wr_en, rf_mem[12], rf_mem[13], wr_count - wr_snap);
    end
    // Pointer was 1 before reset; it must restart at requester 0.
    step();
    drive(0, 1'b1, '{addr: 5'd20, data: 64'hE0});
    drive(1, 1'b1, '{addr: 5'd21, data: 64'hE1});
    step();
    drive(0, 1'b0, '{addr: 5'd0, data: 64'h0});
    drive(1, 1'b0, '{addr: 5'd0, data: 64'h0});
    @(negedge clk);
    vectors++;
    if ({bus.grant_idx, bus.rf_wr_addr} !== {1'b0, 5'd20}) begin
      miscompares++;
      $display("FAIL mid_ptr: got grant=%0d addr=%0d want 0/20", bus.grant_idx, bus.rf_wr_addr);
    end
    step();
    @(negedge clk);
    vectors++;
    if ({bus.grant_idx, bus.rf_wr_addr} !== {1'b1, 5'd21}) begin
      miscompares++;
      $display("FAIL mid_ptr2: got grant=%0d addr=%0d want 1/21", bus.grant_idx, bus.rf_wr_addr);
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_contention();
    test_back_to_back();
    test_busy_collision();
    test_single();
    test_zero_addr();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
